// File: rtl/binoc_ch_dir_ctrl.sv
// Per-link direction controller for BiNoC bidirectional channels.
// One request/grant FSM per link decides when ownership passes to the neighbour.
module binoc_ch_dir_ctrl #(
    parameter int unsigned               NUM_CH    = 2,
    parameter logic [NUM_CH-1:0]         INIT_OWN  = 2'b01,
    parameter int unsigned               MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] tx_want,
    input  logic [NUM_CH-1:0] tx_tail,
    input  logic [NUM_CH-1:0] peer_req,
    input  logic [NUM_CH-1:0] peer_gnt,
    output logic [NUM_CH-1:0] my_req,
    output logic [NUM_CH-1:0] my_gnt,
    output logic [NUM_CH-1:0] own,
    output logic              proto_err
);

    typedef enum logic [1:0] {
        OUT_FREE = 2'd0,
        OUT_BUSY = 2'd1,
        IN_IDLE  = 2'd2,
        IN_WAIT  = 2'd3
    } state_e;

    localparam logic [4:0] MAX_B = 5'(MAX_BURST);

    state_e            state_q [NUM_CH];
    state_e            state_d [NUM_CH];
    logic [3:0]        cnt_q   [NUM_CH];
    logic [3:0]        cnt_d   [NUM_CH];
    logic [NUM_CH-1:0] req_q, req_d;
    logic [NUM_CH-1:0] gnt_q, gnt_d;
    logic [NUM_CH-1:0] own_q, own_d;
    logic              err_q, err_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                state_q[i] <= INIT_OWN[i] ? OUT_FREE : IN_IDLE;
                cnt_q[i]   <= '0;
            end
            req_q <= '0;
            gnt_q <= '0;
            own_q <= INIT_OWN;
            err_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            req_q <= req_d;
            gnt_q <= gnt_d;
            own_q <= own_d;
            err_q <= err_d;
        end
    end

    always_comb begin
        req_d = '0;
        gnt_d = '0;
        own_d = own_q;
        err_d = err_q;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];

            case (state_q[i])
                OUT_FREE, OUT_BUSY: begin
                    own_d[i] = 1'b1;
                    if (!peer_req[i]) begin
                        cnt_d[i] = '0;
                    end
                    if (tx_want[i] && tx_tail[i]) begin
                        // A completed packet is a boundary: either hand over on the
                        // burst limit, or park in OUT_FREE where a falling tx_want
                        // next cycle lets a pending peer request win.
                        if (peer_req[i] && (({1'b0, cnt_q[i]} + 5'd1) >= MAX_B)) begin
                            gnt_d[i]   = 1'b1;
                            own_d[i]   = 1'b0;
                            state_d[i] = IN_IDLE;
                            cnt_d[i]   = '0;
                        end else begin
                            state_d[i] = OUT_FREE;
                            if (peer_req[i]) begin
                                cnt_d[i] = ({1'b0, cnt_q[i]} >= MAX_B) ? MAX_B[3:0]
                                                                        : cnt_q[i] + 4'd1;
                            end
                        end
                    end else if (tx_want[i]) begin
                        state_d[i] = OUT_BUSY;
                    end else if ((state_q[i] == OUT_FREE) && peer_req[i]) begin
                        gnt_d[i]   = 1'b1;
                        own_d[i]   = 1'b0;
                        state_d[i] = IN_IDLE;
                        cnt_d[i]   = '0;
                    end
                end
                IN_IDLE: begin
                    own_d[i] = 1'b0;
                    cnt_d[i] = '0;
                    if (tx_want[i]) begin
                        req_d[i]   = 1'b1;
                        state_d[i] = IN_WAIT;
                    end
                end
                IN_WAIT: begin
                    own_d[i] = 1'b0;
                    cnt_d[i] = '0;
                    req_d[i] = 1'b1;
                    if (peer_gnt[i]) begin
                        req_d[i]   = 1'b0;
                        own_d[i]   = 1'b1;
                        state_d[i] = tx_want[i] ? OUT_BUSY : OUT_FREE;
                    end
                    if (peer_req[i]) begin
                        err_d = 1'b1;
                    end
                end
                default: begin
                    state_d[i] = IN_IDLE;
                    own_d[i]   = 1'b0;
                    cnt_d[i]   = '0;
                end
            endcase

            if (peer_gnt[i] && (state_q[i] != IN_WAIT)) begin
                err_d = 1'b1;
            end
            if (tx_tail[i] && !own_q[i]) begin
                err_d = 1'b1;
            end
        end
    end

    assign my_req    = req_q;
    assign my_gnt    = gnt_q;
    assign own       = own_q;
    assign proto_err = err_q;

endmodule

// File: tb/tb_binoc_ch_dir_ctrl.sv
// Directed bench for binoc_ch_dir_ctrl: per-step expected outputs go through a scoreboard queue.
module tb_binoc_ch_dir_ctrl;

    logic       clk;
    logic       rst;
    logic [1:0] tx_want;
    logic [1:0] tx_tail;
    logic [1:0] peer_req;
    logic [1:0] peer_gnt;
    logic [1:0] my_req;
    logic [1:0] my_gnt;
    logic [1:0] own;
    logic       proto_err;

    typedef struct {
        logic [1:0] req;
        logic [1:0] gnt;
        logic [1:0] own;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   stepno = 0;

    binoc_ch_dir_ctrl #(
        .NUM_CH   (2),
        .INIT_OWN (2'b01),
        .MAX_BURST(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_want  (tx_want),
        .tx_tail  (tx_tail),
        .peer_req (peer_req),
        .peer_gnt (peer_gnt),
        .my_req   (my_req),
        .my_gnt   (my_gnt),
        .own      (own),
        .proto_err(proto_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic push_exp(input logic [1:0] r, input logic [1:0] g,
                            input logic [1:0] o, input logic e);
        exp_t x;
        x.req = r;
        x.gnt = g;
        x.own = o;
        x.err = e;
        sb.push_back(x);
    endtask

    task automatic compare_head();
        exp_t x;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL step%0d scoreboard empty got 0 entries want 1", stepno);
        end else begin
            x = sb.pop_front();
            checks++;
            assert (my_req === x.req) else begin
                errors++;
                $error("FAIL step%0d my_req got %b want %b", stepno, my_req, x.req);
            end
            checks++;
            assert (my_gnt === x.gnt) else begin
                errors++;
                $error("FAIL step%0d my_gnt got %b want %b", stepno, my_gnt, x.gnt);
            end
            checks++;
            assert (own === x.own) else begin
                errors++;
                $error("FAIL step%0d own got %b want %b", stepno, own, x.own);
            end
            checks++;
            assert (proto_err === x.err) else begin
                errors++;
                $error("FAIL step%0d proto_err got %b want %b", stepno, proto_err, x.err);
            end
        end
    endtask

    // Drive one cycle of inputs just after a rising edge, expect outputs after the next edge.
    task automatic step(input logic [1:0] tw, input logic [1:0] tt,
                        input logic [1:0] pr, input logic [1:0] pg,
                        input logic [1:0] er, input logic [1:0] eg,
                        input logic [1:0] eo, input logic ee);
        stepno++;
        tx_want  = tw;
        tx_tail  = tt;
        peer_req = pr;
        peer_gnt = pg;
        push_exp(er, eg, eo, ee);
        @(posedge clk);
        #1;
        compare_head();
    endtask

    initial begin
        rst      = 1'b1;
        tx_want  = '0;
        tx_tail  = '0;
        peer_req = '0;
        peer_gnt = '0;
        #1 rst = 1'b0;
        #2;
        push_exp(2'b00, 2'b00, 2'b01, 1'b0);
        compare_head();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;

        // Free link 0 granted to peer; link 1 untouched
        step(2'b00, 2'b00, 2'b01, 2'b00,  2'b00, 2'b01, 2'b00, 1'b0);
        step(2'b00, 2'b00, 2'b00, 2'b00,  2'b00, 2'b00, 2'b00, 1'b0);
        // Link 1 requests and receives the grant
        step(2'b10, 2'b00, 2'b00, 2'b00,  2'b10, 2'b00, 2'b00, 1'b0);
        step(2'b10, 2'b00, 2'b00, 2'b10,  2'b00, 2'b00, 2'b10, 1'b0);
        // Link 1 finishes a packet; link 0 requests back
        step(2'b11, 2'b10, 2'b00, 2'b00,  2'b01, 2'b00, 2'b10, 1'b0);
        step(2'b01, 2'b00, 2'b00, 2'b01,  2'b00, 2'b00, 2'b11, 1'b0);
        // Burst limit: four single-flit packets with peer request pending
        step(2'b01, 2'b01, 2'b01, 2'b00,  2'b00, 2'b00, 2'b11, 1'b0);
        step(2'b01, 2'b01, 2'b01, 2'b00,  2'b00, 2'b00, 2'b11, 1'b0);
        step(2'b01, 2'b01, 2'b01, 2'b00,  2'b00, 2'b00, 2'b11, 1'b0);
        step(2'b01, 2'b01, 2'b01, 2'b00,  2'b00, 2'b01, 2'b10, 1'b0);
        step(2'b00, 2'b00, 2'b00, 2'b00,  2'b00, 2'b00, 2'b10, 1'b0);
        // Multi-flit packet on link 1, release only after the tail
        step(2'b10, 2'b00, 2'b00, 2'b00,  2'b00, 2'b00, 2'b10, 1'b0);
        step(2'b10, 2'b00, 2'b10, 2'b00,  2'b00, 2'b00, 2'b10, 1'b0);
        step(2'b10, 2'b00, 2'b10, 2'b00,  2'b00, 2'b00, 2'b10, 1'b0);
        step(2'b10, 2'b10, 2'b10, 2'b00,  2'b00, 2'b00, 2'b10, 1'b0);
        step(2'b00, 2'b00, 2'b10, 2'b00,  2'b00, 2'b10, 2'b00, 1'b0);
        step(2'b00, 2'b00, 2'b00, 2'b00,  2'b00, 2'b00, 2'b00, 1'b0);
        // Link 0 request persists after tx_want drops; grant still accepted
        step(2'b01, 2'b00, 2'b00, 2'b00,  2'b01, 2'b00, 2'b00, 1'b0);
        step(2'b00, 2'b00, 2'b00, 2'b00,  2'b01, 2'b00, 2'b00, 1'b0);
        step(2'b00, 2'b00, 2'b00, 2'b01,  2'b00, 2'b00, 2'b01, 1'b0);
        // tx_want beats peer_req in OUT_FREE; stray grant flags an error
        step(2'b01, 2'b00, 2'b01, 2'b00,  2'b00, 2'b00, 2'b01, 1'b0);
        step(2'b01, 2'b00, 2'b01, 2'b01,  2'b00, 2'b00, 2'b01, 1'b1);
        step(2'b01, 2'b00, 2'b00, 2'b00,  2'b00, 2'b00, 2'b01, 1'b1);
        // Link 1 into IN_WAIT, then asynchronous reset mid-handshake
        step(2'b11, 2'b00, 2'b00, 2'b00,  2'b10, 2'b00, 2'b01, 1'b1);
        step(2'b11, 2'b00, 2'b00, 2'b00,  2'b10, 2'b00, 2'b01, 1'b1);

        tx_want  = '0;
        tx_tail  = '0;
        peer_req = '0;
        peer_gnt = '0;
        #2 rst = 1'b0;
        #1;
        stepno++;
        push_exp(2'b00, 2'b00, 2'b01, 1'b0);
        compare_head();
        @(posedge clk);
        #1 rst = 1'b1;
        step(2'b00, 2'b00, 2'b00, 2'b00,  2'b00, 2'b00, 2'b01, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/binoc_ch_dir_ctrl.md
Name: binoc_ch_dir_ctrl

Overview:
- Per-channel direction controller for the bidirectional links between two neighbouring BiNoC routers.
- Each of NUM_CH links between a router port and its neighbour is owned, and driven, by exactly one side at a time.
- This block runs one request/grant FSM per link and decides when ownership transfers. It enforces packet-boundary release and a starvation bound.
- One instance sits on each router port (west/east/north/south); its peer is the neighbour's instance.

Parameters:
- NUM_CH, 2, number of bidirectional links on this port.
- INIT_OWN, 2'b01, per-link reset ownership (bit i = 1 means this side owns link i). The peer instance uses the complement.
- MAX_BURST, 4, packets this side may send on a link while a peer request is pending before it must release (range 1..15).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- tx_want  in  NUM_CH  local output buffer has a flit queued for link i
- tx_tail  in  NUM_CH  the flit sent on link i this cycle is a tail flit; only valid when own[i]=1 and tx_want[i]=1
- peer_req  in  NUM_CH  neighbour requests ownership of link i (level)
- peer_gnt  in  NUM_CH  neighbour grants link i to this side (1-cycle pulse)
- my_req  out  NUM_CH  request ownership of link i from neighbour (level, registered)
- my_gnt  out  NUM_CH  grant link i to neighbour (1-cycle pulse, registered)
- own  out  NUM_CH  this side drives link i; the datapath may send only when own[i]=1 (registered)
- proto_err  out  1  sticky: protocol violation detected

Behaviour:
- Reset (rst=0, async): per link, state = OUT_FREE if INIT_OWN[i] else IN_IDLE; own = INIT_OWN; my_req = 0; my_gnt = 0; burst counters = 0; proto_err = 0. Reset asserted mid-handshake aborts the handshake immediately.
- Links are fully independent; all outputs are registered, so every decision appears one cycle after the inputs that caused it.
- State OUT_FREE (own=1, idle):
  - If tx_want=1, go to OUT_BUSY. tx_want has priority over a simultaneous peer_req.
  - Else if peer_req=1, pulse my_gnt for one cycle, drop own in the same cycle, go to IN_IDLE.
- State OUT_BUSY (own=1, sending):
  - Each cycle with tx_want & tx_tail, one packet completes.
  - While peer_req=1, burst_cnt increments on each completed packet. burst_cnt clears when peer_req=0 or when the link leaves OUT_*.
  - At a completed packet, the link releases if peer_req=1 and either tx_want falls next cycle or burst_cnt+1 == MAX_BURST. Release means: my_gnt pulse, own=0, go to IN_IDLE.
  - At a completed packet with peer_req=0 and tx_want=0 next cycle, go to OUT_FREE.
  - The link never releases mid-packet.
- State IN_IDLE (own=0): if tx_want=1, set my_req=1 and go to IN_WAIT.
- State IN_WAIT (own=0, my_req=1):
  - On peer_gnt=1: my_req=0, own=1 next cycle. Go to OUT_BUSY if tx_want else OUT_FREE.
  - If tx_want drops before the grant arrives, keep requesting; the grant is still accepted.
- Dead cycle: from the cycle my_gnt rises, neither side owns the link until the peer registers own=1. Minimum turnaround is 2 cycles (grant registered, then peer own). The bus is never driven by both sides.
- proto_err sets (sticky until reset) on any of:
  - peer_gnt while not in IN_WAIT;
  - peer_req while in IN_WAIT (both sides requesting);
  - tx_tail while own=0.
- On peer_gnt outside IN_WAIT, the state is unchanged and the grant is ignored.
- burst_cnt saturates at MAX_BURST; it has 4 bits.

Test Plan:
- Reset with INIT_OWN=2'b01, then peer_req=2'b01 and tx_want=0 → next cycle my_gnt=2'b01 for one cycle, own=2'b00. Link 1 remains own=0.
- Link 1 in IN_IDLE, tx_want[1]=1 → my_req[1]=1 the next cycle. Pulse peer_gnt[1] at cycle t → own[1]=1 and my_req[1]=0 at t+1; the link is in OUT_BUSY.
- Link 0 in OUT_BUSY, single-flit packets back-to-back (tx_want=tx_tail=1), peer_req[0] held from cycle 0, MAX_BURST=4 → exactly 4 tails are sent, my_gnt[0] pulses the cycle after the 4th tail, own[0]=0. No tail is accepted after release.
- Multi-flit packet (head, body, body, tail) with peer_req asserted at the first body and tx_want dropping after the tail → release only after the tail. own stays 1 for all 4 flits.
- OUT_FREE with tx_want=1 and peer_req=1 in the same cycle → OUT_BUSY, no my_gnt. Then pulse peer_gnt while owning → proto_err=1, own unchanged.
- Assert rst=0 while link 1 is in IN_WAIT → my_req, my_gnt and proto_err clear immediately; own returns to INIT_OWN asynchronously.
